// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// The bit period is BAUD clock cycles and tx comes straight from a flop.
module uart_tx #(
    parameter int unsigned BAUD = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT
    } state_t;

    localparam logic [27:0] DIV_LAST = 28'(BAUD - 1);

    state_t      state;
    state_t      state_nx;
    logic [9:0]  shreg;
    logic [27:0] div_cnt;
    logic [3:0]  bit_cnt;
    logic        accept;
    logic        wrap;
    logic        last;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        ready    = (state == IDLE);
        wrap     = (state != IDLE) && (div_cnt == DIV_LAST);
        last     = wrap && (bit_cnt == 4'd9);
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = START;
                end
            end
            START:   if (wrap) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // tx is loaded with the bit that becomes the shift register LSB, so the
    // line tracks shreg[0] one flop deep; after the stop bit the fill 1 keeps it high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else if (accept) begin
            shreg   <= {1'b1, data, 1'b0};
            div_cnt <= '0;
            bit_cnt <= '0;
            tx      <= 1'b0;
        end else if (state != IDLE) begin
            if (wrap) begin
                div_cnt <= '0;
                shreg   <= {1'b1, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= shreg[1];
            end else begin
                div_cnt <= div_cnt + 28'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a BAUD=4 instance against a queue-based line model and
// a frame table, and a default-BAUD instance against a sampling receiver.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst, start, ready, tx;
    logic [7:0] data;
    logic       rst2, start2, ready2, tx2;
    logic [7:0] data2;

    always #5 clk = ~clk;

    uart_tx #(.BAUD(4)) dut (
        .clk(clk), .rst(rst), .data(data), .start(start), .ready(ready), .tx(tx)
    );

    uart_tx dut2 (
        .clk(clk), .rst(rst2), .data(data2), .start(start2), .ready(ready2), .tx(tx2)
    );

    int checks = 0;
    int errors = 0;
    bit q[$];   // expected line level for each remaining cycle of the current frame

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit k = line level during bit period k
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock for the BAUD=4 instance: advance the model, then compare.
    task automatic tick();
        bit b;
        @(posedge clk);
        if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (rst && start) begin
            for (int k = 0; k < 10; k++) begin
                b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : data[k-1];
                repeat (4) q.push_back(b);
            end
        end
        #1;
        chk("model_tx", tx, (q.size() > 0) ? q[0] : 1'b1);
        chk("model_ready", ready, q.size() == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   low_cnt, ones;
        logic txs[82];
        logic rdys[82];
        logic [9:0] rx;
        logic       steady;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};
        vecs[5] = '{8'h55, 10'b1010101010};

        rst = 1'b0; rst2 = 1'b0;
        start = 1'b0; start2 = 1'b0; data = '0; data2 = '0;

        // Reset holds the line idle whatever the inputs do.
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); data = 8'($urandom);
            start2 = 1'($urandom); data2 = 8'($urandom);
            #7;
            chk("rst_tx", tx, 1'b1);
            chk("rst_ready", ready, 1'b1);
            chk("rst_tx2", tx2, 1'b1);
            chk("rst_ready2", ready2, 1'b1);
        end
        start = 1'b0; start2 = 1'b0;
        @(negedge clk);
        rst = 1'b1; rst2 = 1'b1;
        repeat (100) tick();

        // Table frames with a one-cycle start pulse; data scrambled after acceptance.
        foreach (vecs[v]) begin
            data = vecs[v].data; start = 1'b1;
            low_cnt = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (c == 0) begin
                    start = 1'b0;
                    data  = ~vecs[v].data;
                end
                if (!ready) low_cnt++;
                chk("table_tx", tx, vecs[v].frame[c / 4]);
            end
            tick();
            chk("table_ready_after", ready, 1'b1);
            chk_int("table_ready_low", low_cnt, 40);
            repeat (3) tick();
        end

        // start held high: frames back to back with one idle cycle between.
        data = 8'h55; start = 1'b1;
        for (int i = 0; i < 82; i++) begin
            tick();
            txs[i] = tx; rdys[i] = ready;
        end
        start = 1'b0;
        chk("b2b_gap_tx", txs[40], 1'b1);
        chk("b2b_gap_ready", rdys[40], 1'b1);
        chk("b2b_second_start", txs[41], 1'b0);
        chk("b2b_second_busy", rdys[41], 1'b0);
        ones = 0;
        for (int i = 0; i < 81; i++) if (rdys[i]) ones++;
        chk_int("b2b_idle_cycles", ones, 1);
        repeat (5) tick();

        // Reset asserted during data bit 3 (cycles 16..19 of the frame).
        data = 8'hC3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (17) tick();
        chk("pre_reset_busy", ready, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_ready", ready, 1'b1);
        q.delete();
        repeat (2) tick();
        #2 rst = 1'b1;
        data = 8'h3C; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            chk("post_rst_tx", tx, vecs[3].frame[c / 4]);
        end
        repeat (3) tick();

        // Random traffic against the model.
        for (int it = 0; it < 25; it++) begin
            data = 8'($urandom); start = 1'b1;
            repeat ($urandom_range(1, 60)) tick();
            start = 1'b0;
            data = 8'($urandom);
            repeat ($urandom_range(0, 50)) tick();
        end
        repeat (45) tick();

        // Default BAUD: sample each bit mid-period like a receiver.
        data2 = 8'h41; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; data2 = 8'hBE;
        rx = '1; steady = 1'b1; low_cnt = 0;
        for (int cyc = 0; cyc < 4340; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (!ready2) low_cnt++;
            if (cyc % 434 == 217) rx[cyc / 434] = tx2;
            if (cyc % 434 != 0 && tx2 !== rx[cyc / 434] && cyc % 434 > 217) steady = 1'b0;
        end
        chk_int("dflt_ready_low", low_cnt, 4340);
        chk("dflt_start_bit", rx[0], 1'b0);
        chk("dflt_stop_bit", rx[9], 1'b1);
        chk_int("dflt_byte", int'(rx[8:1]), 32'h41);
        chk("dflt_bit_steady", steady, 1'b1);
        @(posedge clk); #1;
        chk("dflt_ready_end", ready2, 1'b1);
        chk("dflt_tx_end", tx2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter producing 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) on a single line at a bit period set by a clock-cycle divisor. It sits under the command/data sender in the communications subsystem. The client drives a byte and a start request, and uses `ready` to pace successive bytes.

## Interface
- `BAUD`, default 434: bit period in `clk` cycles (434 = 115200 baud at 50 MHz). Legal range 2 to 2^28-1.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `data`  input  8  byte to transmit; sampled only at frame acceptance.
- `start`  input  1  level-sensitive transmit request.
- `ready`  output  1  1 = idle and able to accept a frame; 0 = frame in progress.
- `tx`  output  1  serial line, idle high.

## Operation
- Reset is asynchronous, active-low; clock is `clk`.
- Reset values: `tx`=1, `ready`=1, FSM=IDLE, bit counter=0, divisor counter=0, shift register=0.
- FSM has three states:
  - IDLE: `ready`=1, `tx`=1.
  - START: `tx`=0, `ready`=0.
  - DATA/STOP: shifting; `ready`=0.
- Acceptance: at a rising edge with state IDLE and `start`=1:
  - latch `data` into a 10-bit shift register {1, data[7:0], 0};
  - enter the transmitting state with `ready`=0.
  - `tx` shows the LSB of the shift register (0 = start bit) from that edge.
- Bit timing:
  - a divisor counter counts 0..BAUD-1;
  - on reaching BAUD-1 it wraps to 0, the shift register shifts right one place (fill 1), and the bit counter increments.
- After 10 bit periods (bit counter reaches 10), return to IDLE with `ready`=1 and `tx`=1.
- `tx` is driven from a register (glitch-free); it never depends combinationally on inputs.
- `data` and `start` changes during a frame are ignored. Only the byte latched at acceptance is sent.
- `start` held high continuously: a new frame is accepted on the first edge in IDLE, so frames run back-to-back with exactly one `ready`=1 cycle between them.
- `start` low in IDLE: stay idle indefinitely.
- Reset mid-frame: `tx` returns to 1 and `ready` to 1 immediately (asynchronously), and the partial frame is abandoned. After reset release the next frame starts cleanly.
- Counter widths: divisor counter 28 bits, bit counter 4 bits. No overflow is possible within the legal `BAUD` range.

## Timing
- Latency: `tx` falls on the same edge that samples `start`=1 in IDLE (edge E0).
- Bit k (k=0 start, 1..8 data[k-1], 9 stop) occupies edges E0+k*BAUD through E0+(k+1)*BAUD-1, i.e. exactly BAUD cycles per bit.
- `ready` is 0 from E0 through E0+10*BAUD-1, and 1 from edge E0+10*BAUD.
- Frame duration is 10*BAUD cycles. With `start` held high, the minimum frame-to-frame period is 10*BAUD+1 cycles.
- Handshake: the client asserts `start` with `data` valid while `ready`=1. It may drop `start` any time after seeing `ready`=0, or keep it high to stream the same `data` input.

## Test plan
- Reset: `rst`=0 with random inputs gives `tx`=1 and `ready`=1. Release `rst` with `start`=0 for 100 cycles: no change.
- Single frame, BAUD=4, `data`=8'hA5, 1-cycle `start` pulse:
  - `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1;
  - `ready` is 0 for exactly 40 cycles, then 1.
- Data hold: BAUD=4, send 8'h00, change `data` to 8'hFF mid-frame → the line still shows eight 0 data bits.
- Back-to-back: BAUD=4, `start` held high, `data`=8'h55 → two frames separated by exactly one idle cycle with `tx`=1 and `ready`=1. The second start bit falls at cycle 41 relative to the first.
- Reset mid-frame: BAUD=4, assert `rst`=0 during data bit 3 → `tx`=1 and `ready`=1 immediately. After release, a new frame with 8'h3C transmits correctly.
- Default BAUD=434, `data`=8'h41 ('A') → each bit lasts 434 cycles, frame is 4340 cycles, and a UART receiver model decodes 0x41.
